// File: rtl/count_pwm_gen.sv
// PWM generator driven by an external synchronous up-counter.
// Duty is shadowed and reloaded on counter wrap; start/stop via en.
module count_pwm_gen #(
    parameter int WIDTH = 4,
    parameter int CYC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm,
    output logic             wrap,
    output logic [CYC_W-1:0] cycles
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_cnt_q;
    logic [WIDTH-1:0] r_duty_act;
    logic [WIDTH-1:0] r_duty_pend;
    logic             r_pend;
    logic             r_pwm;
    logic             r_wrap;
    logic [CYC_W-1:0] r_cycles;

    logic             w_wrap;
    logic             w_idle;
    logic             w_live;
    logic             w_xfer;
    logic             w_ready;
    logic             w_reload;
    logic [WIDTH-1:0] w_duty_eff;
    logic             w_pwm_next;

    // A backward step of the counter is treated exactly like a wrap.
    assign w_wrap     = (cnt < r_cnt_q);
    assign w_idle     = (r_state == S_IDLE);
    assign w_live     = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_ready    = w_idle || !r_pend;
    assign w_xfer     = duty_valid && w_ready;
    assign w_reload   = !w_idle && w_wrap && r_pend;
    assign w_duty_eff = w_reload ? r_duty_pend : r_duty_act;

    always_comb begin
        w_next     = r_state;
        w_pwm_next = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (en) w_next = S_ARM;
            end
            S_ARM: begin
                if (!en)        w_next = S_IDLE;
                else if (w_wrap) w_next = S_RUN;
            end
            S_RUN: begin
                if (!en) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (en)          w_next = S_RUN;
                else if (w_wrap) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if ((w_next == S_RUN) || (w_next == S_DRAIN)) begin
            w_pwm_next = (cnt < w_duty_eff);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt_q     <= '0;
            r_duty_act  <= '0;
            r_duty_pend <= '0;
            r_pend      <= 1'b0;
            r_pwm       <= 1'b0;
            r_wrap      <= 1'b0;
            r_cycles    <= '0;
        end else begin
            r_cnt_q <= cnt;
            r_pwm   <= w_pwm_next;
            r_wrap  <= w_wrap;
            if (w_idle) begin
                if (w_xfer) r_duty_act <= duty_in;
            end else begin
                // A transfer implies no pending value, so it never
                // collides with the reload on the same edge.
                if (w_reload) begin
                    r_duty_act <= r_duty_pend;
                    r_pend     <= 1'b0;
                end
                if (w_xfer) begin
                    r_duty_pend <= duty_in;
                    r_pend      <= 1'b1;
                end
            end
            if (w_idle && (w_next == S_ARM)) begin
                r_cycles <= '0;
            end else if (w_live && w_wrap && !(&r_cycles)) begin
                r_cycles <= r_cycles + 1'b1;
            end
        end
    end

    assign duty_ready = w_ready;
    assign pwm        = r_pwm;
    assign wrap       = r_wrap;
    assign cycles     = r_cycles;

endmodule
